// File: rtl/ldiv_sched_pkg.sv
// ldiv_sched_pkg: shared types for the ldiv scheduler.
//   req_st_e : per-requester state (IDLE / BUSY / DONE)
//   tag_t    : in-flight owner tag {vld, id}, sized for up to 8 requesters
//   id_w()   : index width for a given requester count
package ldiv_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } req_st_e;

  localparam int TAG_ID_W = 3;

  typedef struct packed {
    logic                vld;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ldiv_sched_rr_arb.sv
// ldiv_sched_rr_arb: round-robin arbiter.
//   clk, resetb : clock, async active-low reset
//   elig        : eligible requesters
//   adv         : lets the pointer move past a winner
//   grant       : one-hot (or zero) winner
//   idx         : winner index (0 when no grant)
// The winner is the first eligible index at or after the pointer, wrapping.
module ldiv_sched_rr_arb
  import ldiv_sched_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = id_w(N)
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic [N-1:0]  elig,
  input  logic          adv,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] ptr;
  logic          found;
  int            j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!found && elig[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb)              ptr <= '0;
    else if (adv && found)    ptr <= (int'(idx) == N - 1) ? '0 : idx + IW'(1);
  end

endmodule

// File: rtl/ldiv_sched.sv
// ldiv_sched: shares one pipelined signed divider among NUM_REQ requesters.
//   clk, resetb          : clock, async active-low reset
//   req_valid/req_ready  : per-requester request handshake (ready is combinational)
//   req_numerator/_denominator : flattened operands, slice r = requester r
//   rsp_valid/rsp_ready  : per-requester response handshake
//   rsp_quotient/_remainder/_divzero : flattened response registers
//   div_valid/_numerator/_denominator : registered issue to the divider
//   div_valid_out/_quotient/_remainder : divider results, NUMERATOR_WIDTH later
// Optional: `define LDIV_SCHED_DIVZERO_EN answers zero denominators locally
// (quotient 0, remainder = numerator, divzero flag) without using the divider.
module ldiv_sched
  import ldiv_sched_pkg::*;
#(
  parameter int NUM_REQ           = 4,
  parameter int NUMERATOR_WIDTH   = 24,
  parameter int DENOMINATOR_WIDTH = 20,
  parameter int QUOTIENT_WIDTH    = 24
) (
  input  logic                                   clk,
  input  logic                                   resetb,
  input  logic [NUM_REQ-1:0]                     req_valid,
  output logic [NUM_REQ-1:0]                     req_ready,
  input  logic [NUM_REQ*NUMERATOR_WIDTH-1:0]     req_numerator,
  input  logic [NUM_REQ*DENOMINATOR_WIDTH-1:0]   req_denominator,
  output logic [NUM_REQ-1:0]                     rsp_valid,
  input  logic [NUM_REQ-1:0]                     rsp_ready,
  output logic [NUM_REQ*QUOTIENT_WIDTH-1:0]      rsp_quotient,
  output logic [NUM_REQ*NUMERATOR_WIDTH-1:0]     rsp_remainder,
  output logic [NUM_REQ-1:0]                     rsp_divzero,
  output logic                                   div_valid,
  output logic [NUMERATOR_WIDTH-1:0]             div_numerator,
  output logic [DENOMINATOR_WIDTH-1:0]           div_denominator,
  input  logic                                   div_valid_out,
  input  logic [QUOTIENT_WIDTH-1:0]              div_quotient,
  input  logic [NUMERATOR_WIDTH-1:0]             div_remainder
);

  localparam int NW     = NUMERATOR_WIDTH;
  localparam int DW     = DENOMINATOR_WIDTH;
  localparam int QW     = QUOTIENT_WIDTH;
  localparam int IW     = id_w(NUM_REQ);
  localparam int STAGES = NW;

  logic [NUM_REQ-1:0] idle, elig, grant, tag_hit, bz_hit;
  logic [IW-1:0]      win;
  logic               hs, issue;
  logic [NW-1:0]      sel_num, bz_num;
  logic [DW-1:0]      sel_den;
  tag_t               tag_pipe [STAGES:0];

  // Completion is driven purely by the tag; the divider's valid is advisory.
  logic unused_div_valid_out;
  assign unused_div_valid_out = div_valid_out;

  // Gating with resetb keeps req_ready low while reset is held.
  assign elig      = req_valid & idle & {NUM_REQ{resetb}};
  assign req_ready = grant;
  assign hs        = |grant;

  ldiv_sched_rr_arb #(.N(NUM_REQ)) u_arb (
    .clk    (clk),
    .resetb (resetb),
    .elig   (elig),
    .adv    (1'b1),
    .grant  (grant),
    .idx    (win)
  );

  always_comb begin
    sel_num = '0;
    sel_den = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (grant[r]) begin
        sel_num = req_numerator[r*NW +: NW];
        sel_den = req_denominator[r*DW +: DW];
      end
    end
  end

`ifdef LDIV_SCHED_DIVZERO_EN
  logic               zden;
  logic [NUM_REQ-1:0] bz_own;

  assign zden   = hs && (sel_den == '0);
  assign issue  = hs && !zden;
  assign bz_hit = bz_own;

  // One-cycle bypass register: owner sees DONE two cycles after handshake.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      bz_own <= '0;
      bz_num <= '0;
    end else begin
      bz_own <= zden ? grant : '0;
      if (zden) bz_num <= sel_num;
    end
  end
`else
  assign issue  = hs;
  assign bz_hit = '0;
  assign bz_num = '0;
`endif

  // Issue register and owner tag pipe. Stage 0 loads alongside div_valid, so
  // the last stage lines up with the divider's output NW cycles later.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      div_valid       <= 1'b0;
      div_numerator   <= '0;
      div_denominator <= '0;
      for (int s = 0; s <= STAGES; s++) tag_pipe[s] <= '0;
    end else begin
      div_valid <= issue;
      if (issue) begin
        div_numerator   <= sel_num;
        div_denominator <= sel_den;
      end
      tag_pipe[0].vld <= issue;
      tag_pipe[0].id  <= TAG_ID_W'(win);
      for (int s = 1; s <= STAGES; s++) tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_lane
    req_st_e       st, st_nxt;
    logic [QW-1:0] q;
    logic [NW-1:0] rem;
    logic          dz;

    assign tag_hit[r] = tag_pipe[STAGES].vld && (tag_pipe[STAGES].id == TAG_ID_W'(r));

    always_comb begin
      st_nxt = st;
      case (st)
        ST_IDLE: if (grant[r])                 st_nxt = ST_BUSY;
        ST_BUSY: if (tag_hit[r] || bz_hit[r])  st_nxt = ST_DONE;
        ST_DONE: if (rsp_ready[r])             st_nxt = ST_IDLE;
        default:                               st_nxt = ST_IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
        st  <= ST_IDLE;
        q   <= '0;
        rem <= '0;
        dz  <= 1'b0;
      end else begin
        st <= st_nxt;
        if (st == ST_BUSY && tag_hit[r]) begin
          q   <= div_quotient;
          rem <= div_remainder;
          dz  <= 1'b0;
        end else if (st == ST_BUSY && bz_hit[r]) begin
          q   <= '0;
          rem <= bz_num;
          dz  <= 1'b1;
        end
      end
    end

    assign idle[r]                  = (st == ST_IDLE);
    assign rsp_valid[r]             = (st == ST_DONE);
    assign rsp_quotient[r*QW +: QW] = q;
    assign rsp_remainder[r*NW +: NW] = rem;
    assign rsp_divzero[r]           = dz;
  end

endmodule
